bennett_phase_monitor: RTL
==========================

# bennett_phase_monitor

Receive-side companion to `bennett_clock`. The block samples the `clkn`/`clkp` rail pairs that the generator drives into an adiabatic datapath such as `and16b`. It decodes the Bennett ramp-up / peak / ramp-down sequence, checks it for legality, and captures the datapath result word at the evaluation peak. On each completed, legal Bennett cycle it presents the word with a one-cycle valid pulse. This gives benches and the on-chip result path a single clocked handoff point.

## Interface
Parameters:
- `WIDTH`, 2: number of Bennett stages, i.e. the `clkn`/`clkp` width. Must be ≥1.
- `DATA_W`, 16: width of the captured result word.
- `TIMEOUT`, 64: maximum cycles the level may hold at a nonzero value before it is flagged.

Ports:
- `clk` in 1: single clock. Rails and data are synchronous to it.
- `reset` in 1: asynchronous, active-high.
- `clkn` in WIDTH: negative rails from `bennett_clock`.
- `clkp` in WIDTH: positive rails from `bennett_clock`.
- `data_in` in DATA_W: adiabatic datapath output.
- `err_clr` in 1: one-cycle pulse that leaves ERROR.
- `data_out` out DATA_W: last captured word.
- `data_valid` out 1: one-cycle pulse when a Bennett cycle completes.
- `level` out $clog2(WIDTH+1): number of active stages at the last sample.
- `state` out 3: encoded FSM state.
- `err` out 1: sticky error flag.
- `err_code` out 3: first error cause.
- `cycle_count` out 16: count of completed legal cycles; wraps at 0xFFFF→0.

## Operation
- Stage i is active when `clkp[i]`=1 and `clkn[i]`=0. The active vector is `a = clkp & ~clkn`.
- **Rail fault:** any bit with `clkp[i]==clkn[i]`.
- **Non-thermometer:** `a` is not of the form (1<<k)-1. The k of a legal vector is the sampled level L.
- **FSM states:** IDLE=0, RAMP_UP=1, PEAK=2, RAMP_DOWN=3, ERROR=4.
- **IDLE:**
  - L=0 → stay.
  - L=1 → RAMP_UP.
  - L=WIDTH=1 → PEAK.
- **RAMP_UP:**
  - L=prev+1 → stay, or go to PEAK if L=WIDTH.
  - L=prev → stay.
- **PEAK:**
  - L=WIDTH → stay.
  - L=WIDTH-1 → RAMP_DOWN, or go to IDLE if WIDTH=1.
- **RAMP_DOWN:**
  - L=prev-1 → stay, or go to IDLE if L=0.
  - L=prev → stay.
- **ERROR:** hold until `err_clr`=1, then go to IDLE. `err` and `err_code` clear on the same edge.
- **Error codes:**
  - 1 RAIL
  - 2 NONTHERM
  - 3 SKIP: |L-prev| > 1
  - 4 REVERSAL: decrease in RAMP_UP, or increase in RAMP_DOWN
  - 5 TIMEOUT: hold counter exceeds TIMEOUT while L≠0
  - 6 UNSTABLE: `data_in` changes while in PEAK
- If several errors occur on the same edge, the lowest code wins.
- Any error moves the FSM to ERROR and sets `err`=1.
- `err_code` is latched only when `err` is 0, so it always holds the first cause.
- **Capture:** on the edge where PEAK is entered, `data_in` loads into the shadow register.
- **Completion:** on the RAMP_DOWN→IDLE edge (or PEAK→IDLE when WIDTH=1):
  - `data_out` takes the shadow value.
  - `data_valid`=1 for one cycle.
  - `cycle_count` increments.
- A cycle aborted by an error never produces `data_valid`. `data_out` keeps its old value.

## Timing
- All outputs are registered. Rails are sampled on rising `clk`.
- **Reset values:**
  - `state`=IDLE
  - `level`=0
  - `data_out`=0
  - `data_valid`=0
  - `err`=0
  - `err_code`=0
  - `cycle_count`=0
  - hold counter = 0
- Reset asserted mid-cycle aborts the cycle immediately. No `data_valid` is produced.
- `level` and `state` reflect the rails sampled at the previous edge: 1-cycle latency.
- `data_valid` rises on the same edge that `state` returns to IDLE.
- The hold counter resets on every level change. TIMEOUT fires on the edge where the counter reaches TIMEOUT+1.
- If `err_clr` arrives together with a new error, the new error wins and the FSM stays in ERROR.
- Back-to-back cycles are legal. IDLE may be held for 0 extra cycles.

## Structure
- **Package `bennett_pkg`:**
  - `state_t` enum: IDLE, RAMP_UP, PEAK, RAMP_DOWN, ERROR.
  - `err_code_t` enum: values 0–6.
- **Sub-module `bennett_level_decode`:**
  - Combinational; parameter WIDTH.
  - Inputs: `clkn`, `clkp`.
  - Outputs: `rail_fault`, `non_therm`, `level`.
- The top level holds the FSM, the hold counter, the shadow/data registers and `cycle_count`.

## Test plan
All scenarios use WIDTH=2, DATA_W=16, TIMEOUT=64. "a" below is the active vector.
- **Legal cycle:** a = 00→01→11→01→00, one sample each; `data_in`=A5A5 during PEAK → `data_valid` single pulse, `data_out`=A5A5, `cycle_count`=1, `err`=0.
- **Skip:** a = 00→11 → ERROR, `err_code`=3. Then `err_clr` → IDLE, `err`=0. A following legal cycle with `data_in`=FFFF gives `data_out`=FFFF.
- **Rail fault:** mid-ramp `clkp`=11, `clkn`=01 → `err_code`=1, no `data_valid`, `data_out` unchanged.
- **Reversal and precedence:** a = 01→00 while in RAMP_UP → `err_code`=4. A later error while `err`=1 does not change `err_code`.
- **Timeout and unstable:** hold a=01 for 66 cycles → `err_code`=5. Separately, change `data_in` 0000→0001 during PEAK → `err_code`=6.
- **Reset and wrap:** assert `reset` while in PEAK → all outputs at reset values, no pulse. Preload `cycle_count` to FFFF via 65535 legal cycles; one more legal cycle → 0000.

Source files
------------

// File: rtl/bennett_pkg.sv
// Shared types for the Bennett clock receive-side phase monitor.
package bennett_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    PEAK      = 3'd2,
    RAMP_DOWN = 3'd3,
    ERROR     = 3'd4
  } state_t;

  typedef enum logic [2:0] {
    ERR_NONE     = 3'd0,
    ERR_RAIL     = 3'd1,
    ERR_NONTHERM = 3'd2,
    ERR_SKIP     = 3'd3,
    ERR_REVERSAL = 3'd4,
    ERR_TIMEOUT  = 3'd5,
    ERR_UNSTABLE = 3'd6
  } err_code_t;

endpackage

// File: rtl/bennett_level_decode.sv
// Combinational decode of clkn/clkp rail pairs into an active-stage level
// plus rail-fault and non-thermometer flags.
module bennett_level_decode #(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0]               clkn,
  input  logic [WIDTH-1:0]               clkp,
  output logic                           rail_fault,
  output logic                           non_therm,
  output logic [$clog2(WIDTH+1)-1:0]     level
);

  localparam int LW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] act;
  logic [WIDTH:0]   act_inc;

  always_comb begin
    act        = clkp & ~clkn;
    rail_fault = |(~(clkp ^ clkn));
    // A thermometer code (1<<k)-1 shares no set bit with itself plus one.
    act_inc    = {1'b0, act} + {{WIDTH{1'b0}}, 1'b1};
    non_therm  = |({1'b0, act} & act_inc);
    level      = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      level = level + LW'(act[i]);
    end
  end

endmodule

// File: rtl/bennett_phase_monitor.sv
// Tracks the Bennett ramp-up/peak/ramp-down sequence, flags illegal phases,
// and hands off the datapath word captured at the peak once per legal cycle.
module bennett_phase_monitor
  import bennett_pkg::*;
#(
  parameter int WIDTH   = 2,
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           clkn,
  input  logic [WIDTH-1:0]           clkp,
  input  logic [DATA_W-1:0]          data_in,
  input  logic                       err_clr,
  output logic [DATA_W-1:0]          data_out,
  output logic                       data_valid,
  output logic [$clog2(WIDTH+1)-1:0] level,
  output logic [2:0]                 state,
  output logic                       err,
  output logic [2:0]                 err_code,
  output logic [15:0]                cycle_count
);

  localparam int LW       = $clog2(WIDTH + 1);
  localparam int HOLD_MAX = TIMEOUT + 1;
  localparam int HW       = $clog2(TIMEOUT + 2);

  state_t            state_q, state_d, nxt;
  err_code_t         err_code_q, err_code_d, code;
  logic              err_q, err_d;
  logic              valid_q, valid_d;
  logic [LW-1:0]     level_q, level_d, level_dec;
  logic [HW-1:0]     hold_q, hold_d;
  logic [DATA_W-1:0] shadow_q, shadow_d, data_out_q, data_out_d;
  logic [15:0]       count_q, count_d;
  logic              rail_fault, non_therm;
  logic              f_skip, f_rev, f_to, f_unst, complete;
  int                lvl, prv;

  bennett_level_decode #(.WIDTH(WIDTH)) u_decode (
    .clkn       (clkn),
    .clkp       (clkp),
    .rail_fault (rail_fault),
    .non_therm  (non_therm),
    .level      (level_dec)
  );

  always_comb begin
    state_d    = state_q;
    err_d      = err_q;
    err_code_d = err_code_q;
    shadow_d   = shadow_q;
    data_out_d = data_out_q;
    valid_d    = 1'b0;
    count_d    = count_q;
    level_d    = level_dec;
    nxt        = state_q;
    f_skip     = 1'b0;
    f_rev      = 1'b0;
    f_unst     = 1'b0;
    complete   = 1'b0;
    code       = ERR_NONE;
    lvl        = int'(level_dec);
    prv        = int'(level_q);

    if (level_dec != level_q)                hold_d = '0;
    else if (hold_q == HW'(HOLD_MAX))        hold_d = hold_q;
    else                                     hold_d = hold_q + 1'b1;
    f_to = (state_q != ERROR) && (lvl != 0) && (hold_d == HW'(HOLD_MAX));

    case (state_q)
      IDLE: begin
        if (lvl == 1)      nxt = (WIDTH == 1) ? PEAK : RAMP_UP;
        else if (lvl != 0) f_skip = 1'b1;
      end
      RAMP_UP: begin
        if (lvl == prv + 1)      nxt = (lvl == WIDTH) ? PEAK : RAMP_UP;
        else if (lvl + 1 == prv) f_rev = 1'b1;
        else if (lvl != prv)     f_skip = 1'b1;
      end
      PEAK: begin
        f_unst = (data_in != shadow_q);
        if (lvl == WIDTH - 1) begin
          nxt      = (WIDTH == 1) ? IDLE : RAMP_DOWN;
          complete = (WIDTH == 1);
        end else if (lvl != WIDTH) begin
          f_skip = 1'b1;
        end
      end
      RAMP_DOWN: begin
        if (lvl + 1 == prv) begin
          nxt      = (lvl == 0) ? IDLE : RAMP_DOWN;
          complete = (lvl == 0);
        end else if (lvl == prv + 1) begin
          f_rev = 1'b1;
        end else if (lvl != prv) begin
          f_skip = 1'b1;
        end
      end
      ERROR:   nxt = err_clr ? IDLE : ERROR;
      default: nxt = ERROR;
    endcase

    if (rail_fault)     code = ERR_RAIL;
    else if (non_therm) code = ERR_NONTHERM;
    else if (f_skip)    code = ERR_SKIP;
    else if (f_rev)     code = ERR_REVERSAL;
    else if (f_to)      code = ERR_TIMEOUT;
    else if (f_unst)    code = ERR_UNSTABLE;

    if (code != ERR_NONE) begin
      state_d = ERROR;
      err_d   = 1'b1;
      if (!err_q) err_code_d = code;
    end else begin
      state_d = nxt;
      if (nxt == PEAK && state_q != PEAK) shadow_d = data_in;
      if (complete) begin
        data_out_d = shadow_q;
        valid_d    = 1'b1;
        count_d    = count_q + 16'd1;
      end
      if (state_q == ERROR && nxt == IDLE) begin
        err_d      = 1'b0;
        err_code_d = ERR_NONE;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
      valid_q    <= 1'b0;
      level_q    <= '0;
      hold_q     <= '0;
      shadow_q   <= '0;
      data_out_q <= '0;
      count_q    <= '0;
    end else begin
      state_q    <= state_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
      valid_q    <= valid_d;
      level_q    <= level_d;
      hold_q     <= hold_d;
      shadow_q   <= shadow_d;
      data_out_q <= data_out_d;
      count_q    <= count_d;
    end
  end

  assign data_out    = data_out_q;
  assign data_valid  = valid_q;
  assign level       = level_q;
  assign state       = state_q;
  assign err         = err_q;
  assign err_code    = err_code_q;
  assign cycle_count = count_q;

endmodule
